lmt_writer: RTL and testbench
=============================

Name: lmt_writer

Overview:
- Downstream consumer of the attestation-region modification monitor's `setLMT`/`reset` outputs.
- While `setLMT` is asserted, and once more after it falls, snapshots a free-running 64-bit timestamp and a 16-bit modification-burst count.
- Writes the snapshot into the 8-word LMT region through a dedicated hardware write port. This port is never the CPU or DMA data bus, so the monitor's LMT tamper check does not trigger on it.

Parameters:
- LMT_BASE, 16'h000A, byte address of LMT word 0; word i is at LMT_BASE + 2*i.
- LMT_WORDS, 8, words written per update sequence.
- PRESCALE, 16'd1000, clk cycles per timestamp tick. Used only with LMT_PRESCALE_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- setLMT  input  1  level from the monitor: attested region is being or was just modified
- rata_reset  input  1  kill request from the monitor; synchronous abort
- lmt_wr_ready  input  1  LMT memory accepts the current word at this clk edge
- lmt_wr_en  output  1  write request
- lmt_wr_addr  output  16  byte address of the word being written
- lmt_wr_data  output  16  word being written
- busy  output  1  high in the WRITE state
- time_now  output  64  current timestamp counter

Behaviour:
- Async reset: all of the following are 0 — state=IDLE, lmt_wr_en, lmt_wr_addr, lmt_wr_data, busy, time_now, snapshot, burst_cnt, idx, seen, setLMT_q.
- Timestamp counter:
  - Increments by 1 every clk; wraps 2^64-1 -> 0.
  - Runs regardless of rata_reset or FSM state.
- Burst counter (16-bit):
  - Increments at each edge where setLMT=1 and setLMT_q=0, with setLMT_q being the previous-cycle setLMT register.
  - Wraps 0xFFFF -> 0.
  - Does not increment while rata_reset=1.
- Capture, at an edge in IDLE with setLMT=1 and rata_reset=0:
  - snap_ts <= time_now (pre-increment value).
  - snap_cnt <= post-increment burst count.
  - idx <= 0, seen <= 0, state <= WRITE.
- WRITE state:
  - busy=1, lmt_wr_en=1, lmt_wr_addr = LMT_BASE + 2*idx.
  - Data mapping: idx 0..3 = snap_ts[16*idx+15:16*idx] (little-endian); idx 4 = snap_cnt; idx 5..7 = 16'h0000.
  - Outputs are registered and held stable until an edge with lmt_wr_ready=1; then idx increments.
  - First lmt_wr_en occurs 1 cycle after the capture edge.
- seen flag: set at any edge in WRITE where setLMT=1.
- Last word accepted (idx=LMT_WORDS-1, lmt_wr_ready=1):
  - If seen=1 or setLMT=1: recapture at that edge (same actions as capture), stay in WRITE, no idle bubble.
  - Otherwise: state <= IDLE, lmt_wr_en <= 0.
  - Effect: after setLMT falls, exactly one more full sequence runs, so the stored time is never earlier than the last cycle setLMT was high.
- rata_reset=1 at any edge:
  - state <= IDLE, lmt_wr_en <= 0, idx <= 0, seen <= 0.
  - Partial write is abandoned; burst_cnt and the timestamp are kept.
  - A capture is blocked in the same cycle; capture resumes at the first edge with rata_reset=0 and setLMT=1.
- Simultaneous capture and burst increment in the same edge: the snapshot holds the incremented count.
- lmt_wr_ready while lmt_wr_en=0: ignored.

Optional Feature:
- LMT_PRESCALE_EN defined:
  - A 16-bit prescaler counts 0..PRESCALE-1; time_now increments only when it wraps.
  - PRESCALE=0 or 1 behaves as per-cycle.
  - The prescaler is cleared by reset only.
- Not defined: no prescaler logic; time_now increments every clk.

Test Plan:
- Pulse test: after reset, hold lmt_wr_ready=1, pulse setLMT high 1 cycle at time_now=20. Required: 16 writes total, as two sequences at LMT_BASE 0x000A..0x0018 (the pulse sets seen via the recapture rule). Word 0 of the first sequence = 0x0014, word 4 = 0x0001, words 5..7 = 0.
- Held high: hold setLMT high 30 cycles with lmt_wr_ready=1. Required: back-to-back sequences with no IDLE gap, then exactly one extra sequence after the fall. Final word 4 = 0x0001; final timestamp >= the cycle setLMT fell.
- Backpressure: toggle lmt_wr_ready 0/1 every cycle. Required: addr and data stable while ready=0; each word written exactly once; 8 accepted words per sequence.
- Abort: assert rata_reset for 1 cycle at idx=3. Required: lmt_wr_en=0 next cycle, no further writes. With setLMT=1 the cycle after, a fresh sequence starts at 0x000A.
- Wrap: preload burst_cnt=0xFFFF, new setLMT rise. Required: word 4 = 0x0000.
- With LMT_PRESCALE_EN, PRESCALE=4: time_now=3 after 12 cycles; snapshot word 0 matches.

Source files
------------

// File: rtl/lmt_writer.sv
// -----------------------------------------------------------------------------
// lmt_writer
//
// Purpose:
//   Consumes the modification monitor's setLMT / rata_reset outputs. While setLMT
//   is high, and for one more full sequence after it falls, it snapshots a
//   free-running 64-bit timestamp and a 16-bit modification-burst count. It then
//   writes the snapshot into the 8-word LMT region through a dedicated hardware
//   write port. That port is not the CPU/DMA bus, so the monitor's LMT tamper
//   check does not see these writes.
//
// Word layout (word i at LMT_BASE + 2*i):
//   0..3 : snapshot timestamp, little-endian 16-bit slices
//   4    : snapshot burst count
//   5..7 : zero
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   setLMT       in   attested region is being / was just modified (level)
//   rata_reset   in   kill request from the monitor (synchronous abort)
//   lmt_wr_ready in   LMT memory accepts the presented word at this edge
//   lmt_wr_en    out  write request (registered)
//   lmt_wr_addr  out  byte address of the presented word (registered)
//   lmt_wr_data  out  presented word (registered)
//   busy         out  high while in the WRITE state
//   time_now     out  current timestamp counter
//
// Configuration:
//   LMT_PRESCALE_EN : when defined, time_now advances once every PRESCALE clk
//                     cycles (PRESCALE of 0 or 1 means every cycle). When
//                     undefined, no prescaler exists and time_now advances
//                     every clk.
// -----------------------------------------------------------------------------
module lmt_writer #(
    parameter logic [15:0] LMT_BASE  = 16'h000A,
    parameter int          LMT_WORDS = 8,
    parameter logic [15:0] PRESCALE  = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        setLMT,
    input  logic        rata_reset,
    input  logic        lmt_wr_ready,
    output logic        lmt_wr_en,
    output logic [15:0] lmt_wr_addr,
    output logic [15:0] lmt_wr_data,
    output logic        busy,
    output logic [63:0] time_now
);

    localparam int IDX_W = (LMT_WORDS > 1) ? $clog2(LMT_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LMT_WORDS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       time_q, time_d;
    logic [15:0]       burst_cnt_q, burst_cnt_d;
    logic [63:0]       snap_ts_q, snap_ts_d;
    logic [15:0]       snap_cnt_q, snap_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
    logic              seen_q, seen_d;
    logic              setLMT_q;
    logic              wr_en_q, wr_en_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              rise;
    logic              capture;
    logic              tick;

    // Select the LMT word for a given index from a snapshot.
    function automatic logic [15:0] word_sel(input logic [IDX_W-1:0] i,
                                             input logic [63:0]      ts,
                                             input logic [15:0]      cnt);
        logic [15:0] w;
        w = 16'h0000;
        case (int'(i))
            0:       w = ts[15:0];
            1:       w = ts[31:16];
            2:       w = ts[47:32];
            3:       w = ts[63:48];
            4:       w = cnt;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

`ifdef LMT_PRESCALE_EN
    logic [15:0] presc_q;

    // Wrap point of the prescaler; PRESCALE of 0 or 1 degenerates to per-cycle.
    assign tick = (PRESCALE <= 16'd1) || (presc_q >= PRESCALE - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= 16'h0000;
        end else if (tick) begin
            presc_q <= 16'h0000;
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end
`else
    // No prescaler: advance every cycle. PRESCALE is folded away here.
    assign tick = 1'b1 | (|PRESCALE);
`endif

    assign time_d = tick ? (time_q + 64'd1) : time_q;

    // Burst count bumps on a rising setLMT unless the monitor is killing us.
    assign rise        = setLMT & ~setLMT_q & ~rata_reset;
    assign burst_cnt_d = rise ? (burst_cnt_q + 16'd1) : burst_cnt_q;
    assign idx_inc     = idx_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seen_d     = seen_q;
        snap_ts_d  = snap_ts_q;
        snap_cnt_d = snap_cnt_q;
        wr_en_d    = wr_en_q;
        addr_d     = addr_q;
        data_d     = data_q;
        capture    = 1'b0;

        if (rata_reset) begin
            state_d = IDLE;
            wr_en_d = 1'b0;
            idx_d   = '0;
            seen_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (setLMT) begin
                        capture = 1'b1;
                    end
                end
                WRITE: begin
                    if (setLMT) begin
                        seen_d = 1'b1;
                    end
                    if (lmt_wr_ready) begin
                        if (idx_q == LAST_IDX) begin
                            // Chain straight into a fresh sequence if setLMT was
                            // observed during this one, so the final stored time
                            // is never older than setLMT's last high cycle.
                            if (seen_q || setLMT) begin
                                capture = 1'b1;
                            end else begin
                                state_d = IDLE;
                                wr_en_d = 1'b0;
                                idx_d   = '0;
                            end
                        end else begin
                            idx_d  = idx_inc;
                            addr_d = LMT_BASE + (16'(idx_inc) << 1);
                            data_d = word_sel(idx_inc, snap_ts_q, snap_cnt_q);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // The capturing edge itself counts as an observation of setLMT, so a
        // one-cycle pulse still yields the trailing sequence.
        if (capture) begin
            state_d    = WRITE;
            snap_ts_d  = time_q;
            snap_cnt_d = burst_cnt_d;
            idx_d      = '0;
            seen_d     = setLMT;
            wr_en_d    = 1'b1;
            addr_d     = LMT_BASE;
            data_d     = word_sel('0, time_q, burst_cnt_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            time_q      <= 64'h0;
            burst_cnt_q <= 16'h0;
            snap_ts_q   <= 64'h0;
            snap_cnt_q  <= 16'h0;
            idx_q       <= '0;
            seen_q      <= 1'b0;
            setLMT_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= 16'h0;
            data_q      <= 16'h0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            burst_cnt_q <= burst_cnt_d;
            snap_ts_q   <= snap_ts_d;
            snap_cnt_q  <= snap_cnt_d;
            idx_q       <= idx_d;
            seen_q      <= seen_d;
            setLMT_q    <= setLMT;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign lmt_wr_en   = wr_en_q;
    assign lmt_wr_addr = addr_q;
    assign lmt_wr_data = data_q;
    assign busy        = (state_q == WRITE);
    assign time_now    = time_q;

endmodule

// File: tb/tb_lmt_writer.sv
// -----------------------------------------------------------------------------
// tb_lmt_writer
//
// Directed bench for lmt_writer: reset state, single pulse, held setLMT,
// backpressure, abort, burst-count wrap, asynchronous reset, and (when built
// with LMT_PRESCALE_EN) the timestamp prescaler with PRESCALE=4.
// -----------------------------------------------------------------------------
module tb_lmt_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        setLMT;
    logic        rata_reset;
    logic        lmt_wr_ready;
    logic        lmt_wr_en;
    logic [15:0] lmt_wr_addr;
    logic [15:0] lmt_wr_data;
    logic        busy;
    logic [63:0] time_now;

    lmt_writer #(
        .LMT_BASE (16'h000A),
        .LMT_WORDS(8),
        .PRESCALE (16'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .setLMT      (setLMT),
        .rata_reset  (rata_reset),
        .lmt_wr_ready(lmt_wr_ready),
        .lmt_wr_en   (lmt_wr_en),
        .lmt_wr_addr (lmt_wr_addr),
        .lmt_wr_data (lmt_wr_data),
        .busy        (busy),
        .time_now    (time_now)
    );

    always #5 clk = ~clk;

    // Log of every word the LMT memory accepts.
    logic [15:0] log_addr[$];
    logic [15:0] log_data[$];

    always @(posedge clk) begin
        if (!reset && lmt_wr_en && lmt_wr_ready) begin
            log_addr.push_back(lmt_wr_addr);
            log_data.push_back(lmt_wr_data);
        end
    end

    int total = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check one full 8-word sequence in the log starting at position base.
    task automatic check_seq(input string tag, input int base,
                             input logic [63:0] ts, input logic [15:0] cnt);
        logic [15:0] exp_w[8];
        exp_w[0] = ts[15:0];
        exp_w[1] = ts[31:16];
        exp_w[2] = ts[47:32];
        exp_w[3] = ts[63:48];
        exp_w[4] = cnt;
        exp_w[5] = 16'h0;
        exp_w[6] = 16'h0;
        exp_w[7] = 16'h0;
        if (log_addr.size() < base + 8) begin
            chk({tag, "_present"}, 64'(log_addr.size()), 64'(base + 8));
        end else begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("%s_addr%0d", tag, i), 64'(log_addr[base+i]), 64'(16'h000A + 2*i));
                chk($sformatf("%s_data%0d", tag, i), 64'(log_data[base+i]), 64'(exp_w[i]));
            end
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        setLMT       = 1'b0;
        rata_reset   = 1'b0;
        lmt_wr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int          b;
    int          en_cnt;
    logic [15:0] p_a;
    logic [15:0] p_d;
    logic        p_e;

    initial begin
        reset        = 1'b1;
        setLMT       = 1'b0;
        rata_reset   = 1'b0;
        lmt_wr_ready = 1'b0;
        @(negedge clk);
        chk("rst_en",   64'(lmt_wr_en),   64'd0);
        chk("rst_addr", 64'(lmt_wr_addr), 64'd0);
        chk("rst_data", 64'(lmt_wr_data), 64'd0);
        chk("rst_busy", 64'(busy),        64'd0);
        chk("rst_time", time_now,         64'd0);
        @(negedge clk);
        reset = 1'b0;

`ifdef LMT_PRESCALE_EN
        // Prescaler: one tick every 4 clocks.
        repeat (12) @(negedge clk);
        chk("psc_time", time_now, 64'd3);
        lmt_wr_ready = 1'b1;
        setLMT = 1'b1;
        @(negedge clk);
        setLMT = 1'b0;
        chk("psc_en",    64'(lmt_wr_en),   64'd1);
        chk("psc_addr",  64'(lmt_wr_addr), 64'h000A);
        chk("psc_word0", 64'(lmt_wr_data), 64'h0003);
        repeat (24) @(negedge clk);
        chk("psc_idle", 64'(lmt_wr_en), 64'd0);
        check_seq("psc_seq0", 0, 64'd3, 16'd1);
`else
        // Pulse: setLMT high for one edge at time_now = 20.
        b = log_addr.size();
        lmt_wr_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("pulse_t0", time_now, 64'd20);
        setLMT = 1'b1;
        @(negedge clk);
        setLMT = 1'b0;
        chk("pulse_en1",   64'(lmt_wr_en),   64'd1);
        chk("pulse_busy1", 64'(busy),        64'd1);
        chk("pulse_addr1", 64'(lmt_wr_addr), 64'h000A);
        chk("pulse_data1", 64'(lmt_wr_data), 64'h0014);
        repeat (24) @(negedge clk);
        chk("pulse_en_end",   64'(lmt_wr_en), 64'd0);
        chk("pulse_busy_end", 64'(busy),      64'd0);
        chk("pulse_count", 64'(log_addr.size() - b), 64'd16);
        check_seq("pulse_seq0", b,     64'd20, 16'd1);
        check_seq("pulse_seq1", b + 8, 64'd28, 16'd1);

        // Held high for 30 edges: captures at 10,18,26,34 then one trailing at 42.
        do_reset();
        b = log_addr.size();
        lmt_wr_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_t0", time_now, 64'd10);
        setLMT = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lmt_wr_en) en_cnt++;
            if (i == 29) setLMT = 1'b0;
        end
        chk("held_no_gap", 64'(en_cnt), 64'd40);
        @(negedge clk);
        chk("held_en_end", 64'(lmt_wr_en), 64'd0);
        chk("held_count", 64'(log_addr.size() - b), 64'd40);
        check_seq("held_seq0", b,      64'd10, 16'd1);
        check_seq("held_seq3", b + 24, 64'd34, 16'd1);
        check_seq("held_last", b + 32, 64'd42, 16'd1);

        // Backpressure: ready alternates 0/1 every cycle.
        do_reset();
        b = log_addr.size();
        repeat (5) @(negedge clk);
        chk("bp_t0", time_now, 64'd5);
        setLMT = 1'b1;
        @(negedge clk);
        setLMT = 1'b0;
        for (int i = 0; i < 50; i++) begin
            lmt_wr_ready = ((i % 2) == 1);
            p_a = lmt_wr_addr;
            p_d = lmt_wr_data;
            p_e = lmt_wr_en;
            @(negedge clk);
            if (p_e && !lmt_wr_ready) begin
                chk($sformatf("bp_hold_addr%0d", i), 64'(lmt_wr_addr), 64'(p_a));
                chk($sformatf("bp_hold_data%0d", i), 64'(lmt_wr_data), 64'(p_d));
            end
        end
        chk("bp_count", 64'(log_addr.size() - b), 64'd16);
        check_seq("bp_seq0", b,     64'd5,  16'd1);
        check_seq("bp_seq1", b + 8, 64'd21, 16'd1);

        // Abort at idx 3; setLMT rising together with rata_reset must not count.
        do_reset();
        b = log_addr.size();
        lmt_wr_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("ab_t0", time_now, 64'd8);
        setLMT = 1'b1;
        @(negedge clk);
        setLMT = 1'b0;
        repeat (3) @(negedge clk);
        chk("ab_idx3_addr", 64'(lmt_wr_addr), 64'h0010);
        rata_reset   = 1'b1;
        lmt_wr_ready = 1'b0;
        setLMT       = 1'b1;
        @(negedge clk);
        chk("ab_en_off",   64'(lmt_wr_en), 64'd0);
        chk("ab_busy_off", 64'(busy),      64'd0);
        rata_reset = 1'b0;
        @(negedge clk);
        chk("ab_restart_en",   64'(lmt_wr_en),   64'd1);
        chk("ab_restart_addr", 64'(lmt_wr_addr), 64'h000A);
        chk("ab_restart_data", 64'(lmt_wr_data), 64'h000D);
        setLMT       = 1'b0;
        lmt_wr_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("ab_count", 64'(log_addr.size() - b), 64'd19);
        check_seq("ab_seq_new", b + 3, 64'd13, 16'd1);

        // Burst counter wrap 0xFFFF -> 0.
        do_reset();
        b = log_addr.size();
        lmt_wr_ready = 1'b1;
        force dut.burst_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.burst_cnt_q;
        setLMT = 1'b1;
        @(negedge clk);
        setLMT = 1'b0;
        repeat (20) @(negedge clk);
        chk("wrap_count", 64'(log_addr.size() - b), 64'd16);
        check_seq("wrap_seq0", b,     64'd1, 16'h0000);
        check_seq("wrap_seq1", b + 8, 64'd9, 16'h0000);

        // Asynchronous reset mid-sequence clears outputs before the next edge.
        setLMT = 1'b1;
        @(negedge clk);
        setLMT = 1'b0;
        chk("async_pre_en", 64'(lmt_wr_en), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_en",   64'(lmt_wr_en),   64'd0);
        chk("async_busy", 64'(busy),        64'd0);
        chk("async_addr", 64'(lmt_wr_addr), 64'd0);
        chk("async_time", time_now,         64'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
